// File: rtl/ux607_tlb_ctrl_if.sv
// MMU-side handshakes plus the TLB RAM port of the TLB controller.
// The slave modport is the controller's view; the master modport is the
// view of whoever drives lookups/refills and owns the RAM macro.
`ifndef UX607_TLB_INDEX_WIDTH
`define UX607_TLB_INDEX_WIDTH 5
`endif

interface ux607_tlb_ctrl_if #(
    parameter int AW = `UX607_TLB_INDEX_WIDTH,
    parameter int VW = 27,
    parameter int PW = 44,
    parameter int DW = 1 + VW - AW + PW
) ();
    logic          lkup_valid;
    logic          lkup_ready;
    logic [VW-1:0] lkup_vpn;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_hit;
    logic [PW-1:0] rsp_ppn;
    logic          refill_valid;
    logic          refill_ready;
    logic [VW-1:0] refill_vpn;
    logic [PW-1:0] refill_ppn;
    logic          flush_req;
    logic          flush_busy;
    logic          ram_cs;
    logic          ram_wem;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    modport slave (
        input  lkup_valid, lkup_vpn, rsp_ready, refill_valid, refill_vpn,
               refill_ppn, flush_req, ram_dout,
        output lkup_ready, rsp_valid, rsp_hit, rsp_ppn, refill_ready,
               flush_busy, ram_cs, ram_wem, ram_addr, ram_din
    );

    modport master (
        output lkup_valid, lkup_vpn, rsp_ready, refill_valid, refill_vpn,
               refill_ppn, flush_req, ram_dout,
        input  lkup_ready, rsp_valid, rsp_hit, rsp_ppn, refill_ready,
               flush_busy, ram_cs, ram_wem, ram_addr, ram_din
    );
endinterface

// File: rtl/ux607_tlb_ctrl.sv
// Direct-mapped TLB controller: serves VPN lookups against the TLB RAM,
// writes walker refills, and invalidates every entry after reset and on
// sfence.vma flush. RAM words are packed {valid, tag, ppn}.
`ifndef UX607_TLB_INDEX_WIDTH
`define UX607_TLB_INDEX_WIDTH 5
`endif

module ux607_tlb_ctrl #(
    parameter int AW = `UX607_TLB_INDEX_WIDTH,
    parameter int VW = 27,
    parameter int PW = 44,
    parameter int DW = 1 + VW - AW + PW
) (
    input logic             clk,
    input logic             rst_n,
    ux607_tlb_ctrl_if.slave bus
);
    localparam int DP = 2 ** AW;
    localparam int TW = VW - AW;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_LOOKUP,
        ST_RESP,
        ST_FLUSH
    } state_t;

    state_t        state_q;
    logic [AW-1:0] cnt_q;
    logic          flush_pending_q;
    logic          rsp_valid_q;
    logic          rsp_hit_q;
    logic [PW-1:0] rsp_ppn_q;
    logic [TW-1:0] tag_q;

    logic          is_idle;
    logic          sweeping;
    logic          flush_go;
    logic          refill_fire;
    logic          lkup_fire;
    logic          entry_hit;
    logic          dout_valid;
    logic [TW-1:0] dout_tag;
    logic [PW-1:0] dout_ppn;

    // A flush request in IDLE blocks both handshakes in the same cycle,
    // so neither a refill nor a lookup can slip in ahead of the sweep.
    assign is_idle          = (state_q == ST_IDLE);
    assign sweeping         = (state_q == ST_INIT) || (state_q == ST_FLUSH);
    assign flush_go         = is_idle && (bus.flush_req || flush_pending_q);
    assign bus.refill_ready = is_idle && !flush_go;
    assign bus.lkup_ready   = is_idle && !flush_go && !bus.refill_valid;
    assign refill_fire      = bus.refill_valid && bus.refill_ready;
    assign lkup_fire        = bus.lkup_valid && bus.lkup_ready;

    assign {dout_valid, dout_tag, dout_ppn} = bus.ram_dout;
    assign entry_hit = dout_valid && (dout_tag == tag_q);

    assign bus.flush_busy = sweeping;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_hit    = rsp_hit_q;
    assign bus.rsp_ppn    = rsp_ppn_q;

    // RAM port: sweep writes, same-cycle refill writes and lookup reads.
    always_comb begin
        bus.ram_cs   = 1'b0;
        bus.ram_wem  = 1'b0;
        bus.ram_addr = '0;
        bus.ram_din  = '0;
        if (sweeping) begin
            bus.ram_cs   = 1'b1;
            bus.ram_wem  = 1'b1;
            bus.ram_addr = cnt_q;
        end else if (refill_fire) begin
            bus.ram_cs   = 1'b1;
            bus.ram_wem  = 1'b1;
            bus.ram_addr = bus.refill_vpn[AW-1:0];
            bus.ram_din  = {1'b1, bus.refill_vpn[VW-1:AW], bus.refill_ppn};
        end else if (lkup_fire) begin
            bus.ram_cs   = 1'b1;
            bus.ram_addr = bus.lkup_vpn[AW-1:0];
        end
    end

    // Controller FSM with registered response outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_INIT;
            cnt_q           <= '0;
            flush_pending_q <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_hit_q       <= 1'b0;
            rsp_ppn_q       <= '0;
            tag_q           <= '0;
        end else begin
            case (state_q)
                ST_INIT, ST_FLUSH: begin
                    if (cnt_q == AW'(DP - 1)) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + AW'(1);
                    end
                end
                ST_IDLE: begin
                    if (flush_go) begin
                        flush_pending_q <= 1'b0;
                        cnt_q           <= '0;
                        state_q         <= ST_FLUSH;
                    end else if (lkup_fire) begin
                        tag_q   <= bus.lkup_vpn[VW-1:AW];
                        state_q <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (bus.flush_req) begin
                        flush_pending_q <= 1'b1;
                    end
                    rsp_hit_q   <= entry_hit;
                    rsp_ppn_q   <= entry_hit ? dout_ppn : '0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.flush_req) begin
                        flush_pending_q <= 1'b1;
                    end
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                    cnt_q   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ux607_tlb_ctrl.sv
// Self-checking bench for ux607_tlb_ctrl with a behavioural TLB RAM
// (registered read, write-through on select). Table-driven lookups and
// refills plus hand-written sequences for stalls, flushes and reset.
`timescale 1ns/1ps

module tb_ux607_tlb_ctrl;
    localparam int AW = 5;
    localparam int VW = 27;
    localparam int PW = 44;
    localparam int TW = VW - AW;
    localparam int DW = 1 + TW + PW;
    localparam int DP = 32;

    typedef struct {
        bit            isRefill;
        logic [VW-1:0] vpn;
        logic [PW-1:0] ppn;
        bit            expHit;
        logic [PW-1:0] expPpn;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   writeCount = 0;
    logic [DW-1:0] mem [DP] = '{default: '1};
    vec_t vecs [12];

    ux607_tlb_ctrl_if #(.AW(AW), .VW(VW), .PW(PW), .DW(DW)) bus ();

    ux607_tlb_ctrl #(.AW(AW), .VW(VW), .PW(PW), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: write on select+wem, read data appears next cycle.
    always @(posedge clk) begin
        if (bus.ram_cs) begin
            if (bus.ram_wem) mem[bus.ram_addr] <= bus.ram_din;
            else             bus.ram_dout <= mem[bus.ram_addr];
        end
    end

    // Counts every RAM write so sweeps can be measured.
    always @(posedge clk) begin
        if (bus.ram_cs && bus.ram_wem) writeCount <= writeCount + 1;
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expects to be called at a negedge right after reset release or sweep start.
    task automatic checkInitSweep(input string tag);
        for (int i = 0; i < DP; i++) begin
            #1;
            checkOutput($sformatf("%s_sweep%0d", tag, i),
                {bus.ram_cs, bus.ram_wem, bus.ram_addr, bus.ram_din, bus.rsp_valid, bus.flush_busy},
                {1'b1, 1'b1, AW'(i), {DW{1'b0}}, 1'b0, 1'b1});
            @(negedge clk);
        end
        #1;
        checkOutput($sformatf("%s_busy_low", tag),
            {bus.flush_busy, bus.rsp_valid, bus.lkup_ready}, {1'b0, 1'b0, 1'b1});
        @(negedge clk);
    endtask

    task automatic doRefill(input logic [VW-1:0] vpn, input logic [PW-1:0] ppn);
        int n = 0;
        bus.refill_valid = 1'b1;
        bus.refill_vpn   = vpn;
        bus.refill_ppn   = ppn;
        #1;
        while (!bus.refill_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        checkOutput("refill_ready", bus.refill_ready, 1'b1);
        checkOutput("refill_ram_write",
            {bus.ram_cs, bus.ram_wem, bus.ram_addr, bus.ram_din},
            {1'b1, 1'b1, vpn[AW-1:0], 1'b1, vpn[VW-1:AW], ppn});
        @(negedge clk);
        bus.refill_valid = 1'b0;
    endtask

    task automatic doLookup(input logic [VW-1:0] vpn, output logic hit, output logic [PW-1:0] ppn);
        int n = 0;
        bus.lkup_valid = 1'b1;
        bus.lkup_vpn   = vpn;
        #1;
        while (!bus.lkup_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        checkOutput("lkup_accept", bus.lkup_ready, 1'b1);
        checkOutput("lkup_ram_read",
            {bus.ram_cs, bus.ram_wem, bus.ram_addr, bus.ram_din},
            {1'b1, 1'b0, vpn[AW-1:0], {DW{1'b0}}});
        @(negedge clk);
        bus.lkup_valid = 1'b0;
        #1;
        checkOutput("lkup_lat_t1", bus.rsp_valid, 1'b0);
        @(negedge clk); #1;
        checkOutput("lkup_lat_t2", bus.rsp_valid, 1'b1);
        hit = bus.rsp_hit;
        ppn = bus.rsp_ppn;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        logic          hit;
        logic [PW-1:0] ppn;
        if (v.isRefill) begin
            doRefill(v.vpn, v.ppn);
        end else begin
            doLookup(v.vpn, hit, ppn);
            checkOutput($sformatf("vec%0d_hit", idx), hit, v.expHit);
            checkOutput($sformatf("vec%0d_ppn", idx), ppn, v.expPpn);
        end
    endtask

    // Hard stop in case a sequence wedges despite the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic          hit;
        logic [PW-1:0] ppn;
        int            n;
        int            bad;
        int            wcBefore;

        vecs[0]  = '{1'b0, 27'h0012345, 44'h0,           1'b0, 44'h0};
        vecs[1]  = '{1'b1, 27'h0012345, 44'hABC,         1'b0, 44'h0};
        vecs[2]  = '{1'b0, 27'h0012345, 44'h0,           1'b1, 44'hABC};
        vecs[3]  = '{1'b0, 27'h0022345, 44'h0,           1'b0, 44'h0};
        vecs[4]  = '{1'b1, 27'h0000007, 44'h123,         1'b0, 44'h0};
        vecs[5]  = '{1'b1, 27'h0010007, 44'h456,         1'b0, 44'h0};
        vecs[6]  = '{1'b0, 27'h0000007, 44'h0,           1'b0, 44'h0};
        vecs[7]  = '{1'b0, 27'h0010007, 44'h0,           1'b1, 44'h456};
        vecs[8]  = '{1'b1, 27'h7FFFFFF, 44'hFFFFFFFFFFF, 1'b0, 44'h0};
        vecs[9]  = '{1'b0, 27'h7FFFFFF, 44'h0,           1'b1, 44'hFFFFFFFFFFF};
        vecs[10] = '{1'b0, 27'h000001F, 44'h0,           1'b0, 44'h0};
        vecs[11] = '{1'b0, 27'h0012345, 44'h0,           1'b1, 44'hABC};

        bus.lkup_valid   = 1'b0;
        bus.lkup_vpn     = '0;
        bus.rsp_ready    = 1'b0;
        bus.refill_valid = 1'b0;
        bus.refill_vpn   = '0;
        bus.refill_ppn   = '0;
        bus.flush_req    = 1'b0;

        // Reset state and the power-on invalidate sweep.
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_state",
            {bus.flush_busy, bus.rsp_valid, bus.rsp_hit, bus.rsp_ppn, bus.lkup_ready, bus.refill_ready},
            {1'b1, 1'b0, 1'b0, 44'h0, 1'b0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        checkInitSweep("init");

        // Table-driven lookups and refills.
        for (int i = 0; i < 12; i++) applyStimulus(vecs[i], i);

        // Response stall: outputs hold, no new accept, RAM quiet.
        bus.lkup_valid = 1'b1;
        bus.lkup_vpn   = 27'h0012345;
        #1;
        checkOutput("stall_accept", bus.lkup_ready, 1'b1);
        @(negedge clk);
        bus.lkup_valid = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            #1;
            checkOutput($sformatf("stall_cycle%0d", c),
                {bus.rsp_valid, bus.rsp_hit, bus.rsp_ppn, bus.lkup_ready, bus.ram_cs},
                {1'b1, 1'b1, 44'hABC, 1'b0, 1'b0});
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        #1;
        checkOutput("stall_release_idle", {bus.rsp_valid, bus.lkup_ready}, {1'b0, 1'b1});
        @(negedge clk);

        // Flush pulse during RESP is deferred until after the handshake.
        bus.lkup_valid = 1'b1;
        bus.lkup_vpn   = 27'h0012345;
        @(negedge clk);
        bus.lkup_valid = 1'b0;
        @(negedge clk);
        bus.flush_req = 1'b1;
        @(negedge clk);
        bus.flush_req = 1'b0;
        #1;
        checkOutput("flush_deferred", {bus.rsp_valid, bus.flush_busy}, {1'b1, 1'b0});
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        #1;
        checkOutput("flush_pending_blocks", {bus.lkup_ready, bus.refill_ready}, {1'b0, 1'b0});
        n = 0;
        while (!(bus.ram_cs && bus.ram_wem && bus.flush_busy) && n < 4) begin
            @(negedge clk); #1; n++;
        end
        checkOutput("flush_start",
            {bus.ram_cs, bus.ram_wem, bus.ram_addr, bus.flush_busy},
            {1'b1, 1'b1, AW'(0), 1'b1});
        wcBefore = writeCount;
        n = 0;
        while (bus.flush_busy && n < 40) begin
            @(negedge clk); #1; n++;
        end
        checkOutput("flush_end", bus.flush_busy, 1'b0);
        checkOutput("flush_write_count", 32'(writeCount - wcBefore), 32'd32);
        @(negedge clk);
        doLookup(27'h0012345, hit, ppn);
        checkOutput("post_flush_hit", {hit, ppn}, {1'b0, 44'h0});
        doLookup(27'h0010007, hit, ppn);
        checkOutput("post_flush_hit2", {hit, ppn}, {1'b0, 44'h0});

        // Flush, refill and lookup together: flush wins, refill follows.
        bus.flush_req    = 1'b1;
        bus.refill_valid = 1'b1;
        bus.refill_vpn   = 27'h0000033;
        bus.refill_ppn   = 44'h77;
        bus.lkup_valid   = 1'b1;
        bus.lkup_vpn     = 27'h0000033;
        #1;
        checkOutput("simul_blocked",
            {bus.refill_ready, bus.lkup_ready, bus.ram_cs}, {1'b0, 1'b0, 1'b0});
        @(negedge clk);
        bus.flush_req = 1'b0;
        #1;
        bad = 0;
        n = 0;
        while (bus.flush_busy && n < 40) begin
            if (bus.refill_ready || bus.lkup_ready) bad++;
            @(negedge clk); #1; n++;
        end
        checkOutput("simul_sweep_len", n, DP);
        checkOutput("simul_ready_low", bad, 0);
        checkOutput("simul_refill_after",
            {bus.refill_ready, bus.lkup_ready, bus.ram_cs, bus.ram_wem, bus.ram_addr, bus.ram_din},
            {1'b1, 1'b0, 1'b1, 1'b1, 5'h13, 1'b1, 22'h1, 44'h77});
        @(negedge clk);
        bus.refill_valid = 1'b0;
        bus.lkup_valid   = 1'b0;
        doLookup(27'h0000033, hit, ppn);
        checkOutput("simul_lookup", {hit, ppn}, {1'b1, 44'h77});

        // Reset while a lookup is in flight: no response, sweep restarts.
        bus.lkup_valid = 1'b1;
        bus.lkup_vpn   = 27'h0000033;
        #1;
        checkOutput("rst_lkup_accept", bus.lkup_ready, 1'b1);
        @(negedge clk);
        bus.lkup_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("rst_in_lookup",
            {bus.rsp_valid, bus.flush_busy, bus.ram_addr}, {1'b0, 1'b1, AW'(0)});
        @(negedge clk);
        rst_n = 1'b1;
        checkInitSweep("rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
